// File: rtl/regfile_param.sv
// Parametrised register file: one byte-strobed write port, two registered read
// ports with write-to-read bypass, and a per-entry busy scoreboard.
module regfile_param #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int AW       = 3,
    parameter int ZERO_REG = 0
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [WIDTH/8-1:0] wstrb,
    input  logic [WIDTH-1:0]   wdata,
    input  logic               re_a,
    input  logic [AW-1:0]      raddr_a,
    output logic [WIDTH-1:0]   rdata_a,
    input  logic               re_b,
    input  logic [AW-1:0]      raddr_b,
    output logic [WIDTH-1:0]   rdata_b,
    input  logic               rsv_en,
    input  logic [AW-1:0]      rsv_addr,
    output logic [DEPTH-1:0]   busy
);
    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [WIDTH-1:0] rdata_a_reg, rdata_b_reg;
    logic [WIDTH-1:0] rd_val_a, rd_val_b;
    logic [WIDTH-1:0] wr_old, wr_merged;
    logic [DEPTH-1:0] busy_reg, busy_next;
    logic             wr_valid, rsv_valid;

    // An address is usable when it lies inside the array and is not the
    // hardwired zero entry.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wr_valid  = we && addr_ok(waddr);
    assign rsv_valid = rsv_en && addr_ok(rsv_addr);
    assign wr_old    = wr_valid ? mem_reg[waddr] : '0;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_byte
            assign wr_merged[8*gi +: 8] = wstrb[gi] ? wdata[8*gi +: 8] : wr_old[8*gi +: 8];
        end
    endgenerate

    // Reads of the entry being written see the merged post-write value.
    always_comb begin
        rd_val_a = '0;
        if (addr_ok(raddr_a)) begin
            rd_val_a = (wr_valid && (raddr_a == waddr)) ? wr_merged : mem_reg[raddr_a];
        end
    end

    always_comb begin
        rd_val_b = '0;
        if (addr_ok(raddr_b)) begin
            rd_val_b = (wr_valid && (raddr_b == waddr)) ? wr_merged : mem_reg[raddr_b];
        end
    end

    // Reserve is applied after the write-clear so it wins on the same entry.
    always_comb begin
        busy_next = busy_reg;
        if (wr_valid) begin
            busy_next[waddr] = 1'b0;
        end
        if (rsv_valid) begin
            busy_next[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (clear) begin
                mem_reg[i] <= '0;
            end else if (wr_valid && (waddr == AW'(i))) begin
                mem_reg[i] <= wr_merged;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            rdata_a_reg <= '0;
            rdata_b_reg <= '0;
            busy_reg    <= '0;
        end else begin
            if (re_a) begin
                rdata_a_reg <= rd_val_a;
            end
            if (re_b) begin
                rdata_b_reg <= rd_val_b;
            end
            busy_reg <= busy_next;
        end
    end

    assign rdata_a = rdata_a_reg;
    assign rdata_b = rdata_b_reg;
    assign busy    = busy_reg;
endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: three builds (default, ZERO_REG=1,
// DEPTH=6) driven in lockstep and compared against an array-based model.
module tb_regfile_param;
    logic        clk = 1'b0;
    logic        clear, we, re_a, re_b, rsv_en;
    logic [2:0]  waddr, raddr_a, raddr_b, rsv_addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;

    logic [31:0] ra0, rb0, ra1, rb1, ra2, rb2;
    logic [7:0]  busy0, busy1;
    logic [5:0]  busy2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_param #(.WIDTH(32), .DEPTH(8), .AW(3), .ZERO_REG(0)) u_base (
        .clk(clk), .clear(clear), .we(we), .waddr(waddr), .wstrb(wstrb), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(ra0),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rb0),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(busy0)
    );

    regfile_param #(.WIDTH(32), .DEPTH(8), .AW(3), .ZERO_REG(1)) u_zero (
        .clk(clk), .clear(clear), .we(we), .waddr(waddr), .wstrb(wstrb), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(ra1),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rb1),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(busy1)
    );

    regfile_param #(.WIDTH(32), .DEPTH(6), .AW(3), .ZERO_REG(0)) u_d6 (
        .clk(clk), .clear(clear), .we(we), .waddr(waddr), .wstrb(wstrb), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(ra2),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rb2),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(busy2)
    );

    // Reference model: one set of arrays per build.
    logic [31:0] m_mem [3][8];
    logic [31:0] m_ra [3];
    logic [31:0] m_rb [3];
    logic [7:0]  m_busy [3];
    int          m_depth [3] = '{8, 8, 6};
    int          m_zr [3]    = '{0, 1, 0};

    function automatic bit usable(input int c, input int a);
        return (a < m_depth[c]) && !(m_zr[c] == 1 && a == 0);
    endfunction

    task automatic model_step();
        logic [31:0] post [8];
        for (int c = 0; c < 3; c++) begin
            if (clear) begin
                for (int e = 0; e < 8; e++) m_mem[c][e] = 32'h0;
                m_ra[c]   = 32'h0;
                m_rb[c]   = 32'h0;
                m_busy[c] = 8'h0;
            end else begin
                for (int e = 0; e < 8; e++) post[e] = m_mem[c][e];
                if (we && usable(c, int'(waddr))) begin
                    for (int b = 0; b < 4; b++)
                        if (wstrb[b]) post[waddr][8*b +: 8] = wdata[8*b +: 8];
                end
                if (re_a) m_ra[c] = usable(c, int'(raddr_a)) ? post[raddr_a] : 32'h0;
                if (re_b) m_rb[c] = usable(c, int'(raddr_b)) ? post[raddr_b] : 32'h0;
                if (we && usable(c, int'(waddr))) m_busy[c][waddr] = 1'b0;
                if (rsv_en && usable(c, int'(rsv_addr))) m_busy[c][rsv_addr] = 1'b1;
                for (int e = 0; e < 8; e++) m_mem[c][e] = post[e];
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        clear = 1'b0; we = 1'b0; waddr = 3'd0; wstrb = 4'h0; wdata = 32'h0;
        re_a = 1'b0; raddr_a = 3'd0; re_b = 1'b0; raddr_b = 3'd0;
        rsv_en = 1'b0; rsv_addr = 3'd0;
    endtask

    task automatic set_wr(input int a, input logic [31:0] d, input logic [3:0] s);
        we = 1'b1; waddr = 3'(a); wdata = d; wstrb = s;
    endtask

    // One clock edge: advance the model, then compare every build's outputs.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("base_rdata_a", ra0, m_ra[0]);
        check("base_rdata_b", rb0, m_rb[0]);
        check("base_busy", {24'h0, busy0}, {24'h0, m_busy[0]});
        check("zero_rdata_a", ra1, m_ra[1]);
        check("zero_rdata_b", rb1, m_rb[1]);
        check("zero_busy", {24'h0, busy1}, {24'h0, m_busy[1]});
        check("d6_rdata_a", ra2, m_ra[2]);
        check("d6_rdata_b", rb2, m_rb[2]);
        check("d6_busy", {26'h0, busy2}, {24'h0, m_busy[2]});
    endtask

    initial begin
        idle();
        clear = 1'b1;
        tick();
        tick();
        check("reset_rdata_a", ra0, 32'h0);
        check("reset_busy", {24'h0, busy0}, 32'h0);

        // Preload and reserve 1..7, then clear with a read and write in flight.
        for (int n = 1; n < 8; n++) begin
            idle(); set_wr(n, 32'hA5A5_0000 + 32'(n), 4'hF);
            rsv_en = 1'b1; rsv_addr = 3'(n);
            tick();
        end
        check("preload_busy", {24'h0, busy0}, 32'h0000_00FE);
        idle(); clear = 1'b1; re_a = 1'b1; raddr_a = 3'd3;
        set_wr(3, 32'h7777_7777, 4'hF); rsv_en = 1'b1; rsv_addr = 3'd5;
        tick();
        check("clear_rdata_a", ra0, 32'h0);
        check("clear_busy", {24'h0, busy0}, 32'h0);
        for (int n = 0; n < 8; n++) begin
            idle(); re_a = 1'b1; raddr_a = 3'(n);
            tick();
            check("post_clear_read", ra0, 32'h0);
        end

        // Byte strobes.
        idle(); set_wr(2, 32'h1122_3344, 4'b1111); tick();
        idle(); set_wr(2, 32'hAABB_CCDD, 4'b0101); tick();
        idle(); re_b = 1'b1; raddr_b = 3'd2; tick();
        check("strobe_merge", rb0, 32'h11BB_33DD);
        idle(); set_wr(2, 32'hFFFF_FFFF, 4'b0000); re_b = 1'b1; raddr_b = 3'd2; tick();
        check("strobe_none", rb0, 32'h11BB_33DD);

        // Dual read with bypass on port A, then hold with re_a=0.
        idle(); set_wr(4, 32'h4, 4'hF); tick();
        idle(); set_wr(5, 32'hDEAD_BEEF, 4'hF);
        re_a = 1'b1; raddr_a = 3'd5; re_b = 1'b1; raddr_b = 3'd4;
        tick();
        check("bypass_a", ra0, 32'hDEAD_BEEF);
        check("plain_b", rb0, 32'h4);
        idle(); raddr_a = 3'd4; tick();
        check("hold_a", ra0, 32'hDEAD_BEEF);
        idle(); set_wr(4, 32'h0000_1200, 4'b0010);
        re_a = 1'b1; raddr_a = 3'd4; re_b = 1'b1; raddr_b = 3'd4;
        tick();
        check("bypass_both_a", ra0, 32'h0000_1204);
        check("bypass_both_b", rb0, 32'h0000_1204);

        // Scoreboard.
        idle(); rsv_en = 1'b1; rsv_addr = 3'd6; tick();
        check("sb_reserve", {24'h0, busy0}, 32'h40);
        idle(); set_wr(6, 32'h6, 4'hF); rsv_en = 1'b1; rsv_addr = 3'd6; tick();
        check("sb_reserve_wins", {24'h0, busy0}, 32'h40);
        idle(); set_wr(6, 32'h6, 4'hF); tick();
        check("sb_write_clears", {24'h0, busy0}, 32'h00);
        idle(); set_wr(3, 32'h3, 4'hF); rsv_en = 1'b1; rsv_addr = 3'd1; tick();
        check("sb_split", {24'h0, busy0}, 32'h02);

        // Hardwired zero entry (bypass case included).
        idle(); set_wr(0, 32'hFFFF_FFFF, 4'hF); rsv_en = 1'b1; rsv_addr = 3'd0;
        re_a = 1'b1; raddr_a = 3'd0;
        tick();
        check("zero_bypass", ra1, 32'h0);
        check("zero_busy0", {31'h0, busy1[0]}, 32'h0);
        check("base_bypass0", ra0, 32'hFFFF_FFFF);
        idle(); re_b = 1'b1; raddr_b = 3'd0; tick();
        check("zero_read", rb1, 32'h0);

        // DEPTH=6: out-of-range write, read and reserve.
        idle(); clear = 1'b1; tick();
        idle(); set_wr(7, 32'h1234, 4'hF); re_a = 1'b1; raddr_a = 3'd7; tick();
        check("d6_oor_read", ra2, 32'h0);
        check("base_addr7", ra0, 32'h1234);
        idle(); rsv_en = 1'b1; rsv_addr = 3'd6; re_b = 1'b1; raddr_b = 3'd7; tick();
        check("d6_oor_rsv", {26'h0, busy2}, 32'h0);
        check("d6_oor_read_b", rb2, 32'h0);

        // Randomized traffic with occasional clears.
        for (int i = 0; i < 400; i++) begin
            idle();
            clear    = ($urandom_range(0, 31) == 0);
            we       = 1'($urandom_range(0, 1));
            waddr    = 3'($urandom_range(0, 7));
            wstrb    = 4'($urandom);
            wdata    = $urandom;
            re_a     = 1'($urandom_range(0, 1));
            raddr_a  = ($urandom_range(0, 3) == 0) ? waddr : 3'($urandom_range(0, 7));
            re_b     = 1'($urandom_range(0, 1));
            raddr_b  = ($urandom_range(0, 3) == 0) ? waddr : 3'($urandom_range(0, 7));
            rsv_en   = ($urandom_range(0, 2) == 0);
            rsv_addr = ($urandom_range(0, 3) == 0) ? waddr : 3'($urandom_range(0, 7));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised register file with `DEPTH` entries of `WIDTH` bits. It has one write port with byte strobes, two independent registered read ports with write-to-read bypass, and a per-entry busy scoreboard for tracking pending writes. It replaces the fixed 8×32 register bank in the datapath, where the ALU and load unit write and the operand fetch stage reads.

## Interface
- `WIDTH`, 32, data width in bits; must be a multiple of 8.
- `DEPTH`, 8, number of entries; 2..256.
- `AW`, 3, address width; must equal ceil(log2(DEPTH)).
- `ZERO_REG`, 0, when 1, entry 0 is hardwired to zero and cannot be reserved.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `clear` in 1: reset, synchronous, active-high.
- `we` in 1: write enable.
- `waddr` in AW: write address.
- `wstrb` in WIDTH/8: byte write strobes; bit i covers `wdata[8i+7:8i]`.
- `wdata` in WIDTH: write data.
- `re_a` in 1: read enable, port A.
- `raddr_a` in AW: read address, port A.
- `rdata_a` out WIDTH: registered read data, port A.
- `re_b` in 1: read enable, port B.
- `raddr_b` in AW: read address, port B.
- `rdata_b` out WIDTH: registered read data, port B.
- `rsv_en` in 1: reserve (mark busy) request.
- `rsv_addr` in AW: entry to reserve.
- `busy` out DEPTH: scoreboard; bit n = entry n has a pending write.

## Operation
- **Reset:** `clear`=1 at an edge sets all entries to 0, `rdata_a`/`rdata_b` to 0 and `busy` to 0. `clear` overrides every other input in that cycle, including a write or reserve in flight.
- **Write:** at an edge with `we`=1, each byte whose `wstrb` bit is 1 is loaded from `wdata`. Unstrobed bytes hold their value.
  - `we`=1 with `wstrb`=0 changes no data but still clears busy.
  - A write to `waddr` ≥ `DEPTH` is ignored entirely, with no data or busy change.
  - With `ZERO_REG`=1, writes to entry 0 are ignored.
- **Read:** each port is independent. At an edge with `re_x`=1, `rdata_x` loads the entry at `raddr_x`. With `re_x`=0, `rdata_x` holds its previous value.
  - Reading address ≥ `DEPTH` returns 0.
  - Entry 0 always reads 0 when `ZERO_REG`=1.
- **Bypass:** if `re_x`=1 and `raddr_x`==`waddr` with a valid `we`=1 in the same cycle, `rdata_x` receives the post-write value. That value is the strobed bytes from `wdata` merged with the unstrobed bytes of the old entry. Both ports may bypass simultaneously.
- **Scoreboard:**
  - `rsv_en`=1 sets `busy[rsv_addr]`.
  - A valid write clears `busy[waddr]`.
  - If both target the same entry in one cycle, the reserve wins and busy stays 1.
  - Reserving and writing different entries in one cycle updates both bits.
  - Reserve of an out-of-range address is ignored; with `ZERO_REG`=1, reserve of entry 0 is ignored.
  - Re-reserving an already-busy entry keeps it busy (no count).
- Reads never stall on busy; interpreting `busy` is the consumer's responsibility.

## Timing
- Write latency is 1 edge. The data is in the array after the edge and is visible to any read issued in the same cycle via bypass.
- Read latency is 1 cycle. Address and enable are sampled at edge N, and `rdata` is valid after edge N and stable until the next edge with enable.
- `busy` is a registered output and updates 1 edge after `rsv_en` or `we`.
- The outputs have no combinational path from any input.
- `clear` asserted mid-sequence makes the next cycle identical to post-reset state regardless of prior history.

## Test plan
- **Reset:** preload entries 1..7 = 0xA5A5_0000+n, pulse `clear` one cycle with `re_a`=1 on `raddr_a`=3 → `rdata_a`=0 and `busy`=0. Subsequent reads of every entry return 0.
- **Byte strobes:** write entry 2 = 0x1122_3344 (`wstrb`=4'b1111), then write 0xAABB_CCDD with `wstrb`=4'b0101, then read entry 2 on port B → 0x11BB_33DD one cycle after `re_b`.
- **Dual read + bypass:** same cycle: `we`=1, `waddr`=5, `wdata`=0xDEAD_BEEF, full strobes; `raddr_a`=5, `raddr_b`=4 (holds 0x4) → next cycle `rdata_a`=0xDEAD_BEEF, `rdata_b`=0x4. With `re_a`=0 the following cycle, `rdata_a` holds 0xDEAD_BEEF.
- **Scoreboard:** reserve entry 6 → `busy`=8'h40.
  - Next cycle, write entry 6 and reserve entry 6 together → `busy` stays 8'h40.
  - Next cycle, write entry 6 alone → `busy`=8'h00.
  - Reserve 1 and write 3 in one cycle → `busy`=8'h02.
- **ZERO_REG=1 build:** write 0xFFFF_FFFF to entry 0 and reserve entry 0 → reads of entry 0 return 0 (including the bypass case) and `busy[0]` stays 0.
- **DEPTH=6, AW=3 build:** write 0x1234 to address 7 → no entry changes, and a read of address 7 returns 0. A reserve of address 6 leaves `busy`=6'b0.
